reg_bank_arbiter: RTL

- Round-robin write arbiter that shares a bank of NREG n-bit load-enable registers among 4 requesters.
- Sits between requesting datapath units and the register bank.
- Drives one-hot load enables plus a shared write-data bus, so each bank register sees control=1 for exactly one clock per granted write.
- Uses a 4-phase req/ack handshake per requester.

---
 rtl/reg_bank_arbiter_if.sv | 39 +++
 rtl/reg_bank_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter_if.sv
//==============================================================================
// Module : reg_bank_arbiter_if
// Brief  : Requester-side and bank-side signal bundle for reg_bank_arbiter.
//          Defining REG_ARB_LOCK_EN adds the per-requester lock vector.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface reg_bank_arbiter_if #(
    parameter int N    = 16,
    parameter int NREG = 4,
    parameter int AW   = 2
);
    logic [3:0]      req;
    logic [4*AW-1:0] req_addr;
    logic [4*N-1:0]  req_data;
    logic [3:0]      ack;
    logic [NREG-1:0] load;
    logic [N-1:0]    wdata;
    logic            busy;
    logic [1:0]      owner;

`ifdef REG_ARB_LOCK_EN
    logic [3:0]      lock;

    modport master (output req, req_addr, req_data, lock,
                    input  ack, load, wdata, busy, owner);
    modport slave  (input  req, req_addr, req_data, lock,
                    output ack, load, wdata, busy, owner);
`else
    modport master (output req, req_addr, req_data,
                    input  ack, load, wdata, busy, owner);
    modport slave  (input  req, req_addr, req_data,
                    output ack, load, wdata, busy, owner);
`endif

endinterface

`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
//==============================================================================
// Module : reg_bank_arbiter
// Brief  : Round-robin 4-requester write arbiter driving one-hot load enables
//          and shared write data into a bank of NREG registers.
//          Optional macro REG_ARB_LOCK_EN: owner may hold the bank for
//          back-to-back writes while its lock bit is set.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module reg_bank_arbiter #(
    parameter int N    = 16,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic                clk,
    input  logic                resetn,
    reg_bank_arbiter_if.slave   bus
);

    localparam int c_NREQ = 4;

`ifdef REG_ARB_LOCK_EN
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WRITE    = 2'd1,
        S_RELEASE  = 2'd2,
        S_LOCKWAIT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WRITE    = 2'd1,
        S_RELEASE  = 2'd2
    } state_t;
`endif

    state_t          r_state;
    logic [1:0]      r_rr_ptr;
    logic [1:0]      r_owner;
    logic [3:0]      r_ack;
    logic [NREG-1:0] r_load;
    logic [N-1:0]    r_wdata;
    logic            r_busy;

    logic [1:0]      w_winner;
    logic [1:0]      w_grant_idx;
    logic            w_grant;
    logic [AW-1:0]   w_grant_addr;
    logic [N-1:0]    w_grant_data;
    logic [NREG-1:0] w_load_dec;
    logic [3:0]      w_ack_dec;

    // Scan from the farthest offset down so the nearest requester to rr_ptr wins.
    always_comb begin
        w_winner = r_rr_ptr;
        for (int i = c_NREQ - 1; i >= 0; i--) begin
            if (bus.req[r_rr_ptr + 2'(i)]) begin
                w_winner = r_rr_ptr + 2'(i);
            end
        end
    end

`ifdef REG_ARB_LOCK_EN
    assign w_grant_idx = (r_state == S_LOCKWAIT) ? r_owner : w_winner;
    assign w_grant     = ((r_state == S_IDLE) && (|bus.req)) ||
                         ((r_state == S_LOCKWAIT) && bus.req[r_owner]);
`else
    assign w_grant_idx = w_winner;
    assign w_grant     = (r_state == S_IDLE) && (|bus.req);
`endif

    assign w_grant_addr = bus.req_addr[w_grant_idx*AW +: AW];
    assign w_grant_data = bus.req_data[w_grant_idx*N +: N];

    // The address is consumed at the grant edge by registering its decode,
    // so the one-hot load itself acts as the latched target address.
    always_comb begin
        w_load_dec               = '0;
        w_load_dec[w_grant_addr] = 1'b1;
        w_ack_dec                = '0;
        w_ack_dec[w_grant_idx]   = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_ack    <= '0;
            r_load   <= '0;
            r_wdata  <= '0;
            r_busy   <= 1'b0;
        end else if (w_grant) begin
            r_owner <= w_grant_idx;
            r_wdata <= w_grant_data;
            r_load  <= w_load_dec;
            r_ack   <= w_ack_dec;
            r_busy  <= 1'b1;
            r_state <= S_WRITE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                end
                S_WRITE: begin
                    r_load  <= '0;
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!bus.req[r_owner]) begin
                        r_ack <= '0;
`ifdef REG_ARB_LOCK_EN
                        if (bus.lock[r_owner]) begin
                            r_state <= S_LOCKWAIT;
                        end else begin
                            r_rr_ptr <= r_owner + 2'd1;
                            r_busy   <= 1'b0;
                            r_state  <= S_IDLE;
                        end
`else
                        r_rr_ptr <= r_owner + 2'd1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
`endif
                    end
                end
`ifdef REG_ARB_LOCK_EN
                S_LOCKWAIT: begin
                    // Owner let go of the lock while idle: hand the bank back.
                    if (!bus.lock[r_owner]) begin
                        r_rr_ptr <= r_owner + 2'd1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack   = r_ack;
    assign bus.load  = r_load;
    assign bus.wdata = r_wdata;
    assign bus.busy  = r_busy;
    assign bus.owner = r_owner;

endmodule

`default_nettype wire
